// File: rtl/fpu_writeback_if.sv
// fpu_writeback_if: FPU/ALU result, hazard-check and register-file write signals
interface fpu_writeback_if #(
  parameter int WIDTH = 16,
  parameter int RADDR = 4,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic             fpu_valid;
  logic [RADDR-1:0] fpu_rd;
  logic [WIDTH-1:0] fpu_data;
  logic             fpu_ready;
  logic             alu_valid;
  logic [RADDR-1:0] alu_rd;
  logic [WIDTH-1:0] alu_data;
  logic             alu_stall;
  logic [RADDR-1:0] chk_a;
  logic [RADDR-1:0] chk_b;
  logic             hazard;
  logic             rf_we;
  logic [RADDR-1:0] rf_waddr;
  logic [WIDTH-1:0] rf_wdata;
  logic [CW-1:0]    fifo_count;
  modport master (
    output fpu_valid, fpu_rd, fpu_data, alu_valid, alu_rd, alu_data, chk_a, chk_b,
    input  fpu_ready, alu_stall, hazard, rf_we, rf_waddr, rf_wdata, fifo_count
  );
  modport slave (
    input  fpu_valid, fpu_rd, fpu_data, alu_valid, alu_rd, alu_data, chk_a, chk_b,
    output fpu_ready, alu_stall, hazard, rf_we, rf_waddr, rf_wdata, fifo_count
  );
endinterface

// File: rtl/fpu_writeback.sv
// fpu_writeback: in-order FPU result FIFO arbitrated with the ALU onto the register-file write port
module fpu_writeback #(
  parameter int WIDTH = 16,
  parameter int RADDR = 4,
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            reset,
  fpu_writeback_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0]               head_q, head_d;
  logic [PW-1:0]               tail_q, tail_d;
  logic [CW-1:0]               count_q, count_d;
  logic [DEPTH-1:0][RADDR-1:0] ent_rd_q, ent_rd_d;
  logic [DEPTH-1:0][WIDTH-1:0] ent_data_q, ent_data_d;
  logic [DEPTH-1:0]            ent_vld_q, ent_vld_d;
  logic                        rf_we_q, rf_we_d;
  logic [RADDR-1:0]            rf_waddr_q, rf_waddr_d;
  logic [WIDTH-1:0]            rf_wdata_q, rf_wdata_d;
  logic                        full, push, pop, alu_win, hazard;

  assign full    = count_q == CW'(DEPTH);
  assign push    = bus.fpu_valid && !full;
  assign pop     = (count_q != '0) && (full || !bus.alu_valid);
  assign alu_win = bus.alu_valid && !full;

  // RAW hazard against every queued entry and the result being accepted this cycle
  always_comb begin
    hazard = push && (bus.fpu_rd == bus.chk_a || bus.fpu_rd == bus.chk_b);
    for (int i = 0; i < DEPTH; i++)
      hazard = hazard || (ent_vld_q[i] && (ent_rd_q[i] == bus.chk_a || ent_rd_q[i] == bus.chk_b));
  end

  // FIFO push/pop and selection of the write-port winner
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    ent_rd_d   = ent_rd_q;
    ent_data_d = ent_data_q;
    ent_vld_d  = ent_vld_q;
    if (push) begin
      ent_rd_d[tail_q]   = bus.fpu_rd;
      ent_data_d[tail_q] = bus.fpu_data;
      ent_vld_d[tail_q]  = 1'b1;
      tail_d             = tail_q + PW'(1);
    end
    if (pop) begin
      ent_vld_d[head_q] = 1'b0;
      head_d            = head_q + PW'(1);
    end
    count_d    = count_q + CW'(push) - CW'(pop);
    rf_we_d    = pop || alu_win;
    rf_waddr_d = pop ? ent_rd_q[head_q] : alu_win ? bus.alu_rd : rf_waddr_q;
    rf_wdata_d = pop ? ent_data_q[head_q] : alu_win ? bus.alu_data : rf_wdata_q;
  end

  // State register; reset discards any queued results
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ent_rd_q   <= '0;
      ent_data_q <= '0;
      ent_vld_q  <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ent_rd_q   <= ent_rd_d;
      ent_data_q <= ent_data_d;
      ent_vld_q  <= ent_vld_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign bus.fpu_ready  = !full;
  assign bus.alu_stall  = bus.alu_valid && full;
  assign bus.hazard     = hazard;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.fifo_count = count_q;
endmodule
